combo_sweep_ctrl: RTL and testbench

Sequencer that drives the three inputs (a, b, c) of a 3-input combinational gate block through all 8 combinations in ascending binary order. After each vector it waits a programmable settle time, samples y, and assembles the result into an 8-bit truth table. It gives the bench or system logic a single-pulse start/done handshake for characterising any 3-input combo block in hardware, replacing hand-written stimulus sequences.

---
 rtl/combo_sweep_pkg.sv | 19 +
 rtl/combo_sweep_ctrl_settle_timer.sv | 43 ++++
 rtl/combo_sweep_ctrl.sv | 173 +++++++++++++++++
 tb/tb_combo_sweep_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/combo_sweep_pkg.sv
// combo_sweep_pkg: shared types and sizes for the combo_sweep_ctrl sequencer.
//   state_e     - sequencer states (IDLE, SETTLE, SAMPLE, DONE)
//   NUM_VECTORS - number of input combinations swept (8)
//   IDX_W       - width of the vector index (3)
//   SETTLE_W    - width of the settle counter (4, covers SETTLE_CYCLES up to 15)
package combo_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int SETTLE_W    = 4;

endpackage

// File: rtl/combo_sweep_ctrl_settle_timer.sv
// settle_timer: counts cycles while enabled and flags the last settle cycle.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   clear      - zero the count (has priority over enable)
//   enable     - advance the count this cycle
//   expired    - high while enabled and the count equals SETTLE_CYCLES-1
module settle_timer
    import combo_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [SETTLE_W-1:0] LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/combo_sweep_ctrl.sv
// combo_sweep_ctrl: drives {a,b,c} through 000..111, waits SETTLE_CYCLES per
// vector, samples y and assembles an 8-bit truth table (bit i = y for vector i).
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   start       - sweep request, honoured only in IDLE
//   y           - output of the swept combinational block
//   a, b, c     - registered vector bits (a = MSB)
//   busy        - high in SETTLE and SAMPLE
//   done        - one-cycle pulse when the sweep completes
//   truth_table - assembled result, held until the next accepted start
// Optional build macro COMBO_SWEEP_CHECK_EN adds:
//   expected_tt - reference table, latched when start is accepted
//   mismatch    - truth_table differs from expected_tt (valid from DONE)
//   fail_idx    - lowest differing vector index, 0 when no mismatch
module combo_sweep_ctrl
    import combo_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   y,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] truth_table
`ifdef COMBO_SWEEP_CHECK_EN
    ,
    input  logic [NUM_VECTORS-1:0] expected_tt,
    output logic                   mismatch,
    output logic [IDX_W-1:0]       fail_idx
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [2:0]             abc_q, abc_d;
    logic [NUM_VECTORS-1:0] tt_q, tt_d;
    logic                   settle_expired;
    logic                   accept;
    logic                   last_sample;

    assign accept      = (state_q == IDLE) && start;
    assign last_sample = (state_q == SAMPLE) && (idx_q == LAST_IDX);

    // Counter is held at zero outside SETTLE so every settle window starts fresh.
    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  ((state_q != SETTLE) || settle_expired),
        .enable (state_q == SETTLE),
        .expired(settle_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (settle_expired) state_d = SAMPLE;
            SAMPLE:  state_d = (idx_q == LAST_IDX) ? DONE : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == SETTLE) || (state_q == SAMPLE);
        done = (state_q == DONE);
    end

    // Vector index, applied vector and truth table
    always_comb begin
        idx_d = idx_q;
        abc_d = abc_q;
        tt_d  = tt_q;
        if (accept) begin
            idx_d = '0;
            abc_d = 3'b000;
            tt_d  = '0;
        end else if (state_q == SAMPLE) begin
            tt_d[idx_q] = y;
            // idx stops at 7; the sweep ends rather than wrapping.
            if (idx_q != LAST_IDX) begin
                idx_d = idx_q + IDX_W'(1);
                abc_d = idx_q + IDX_W'(1);
            end
        end else if (state_q == DONE) begin
            abc_d = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
            abc_q <= 3'b000;
            tt_q  <= '0;
        end else begin
            idx_q <= idx_d;
            abc_q <= abc_d;
            tt_q  <= tt_d;
        end
    end

    assign a           = abc_q[2];
    assign b           = abc_q[1];
    assign c           = abc_q[0];
    assign truth_table = tt_q;

`ifdef COMBO_SWEEP_CHECK_EN
    logic [NUM_VECTORS-1:0] exp_q;
    logic [NUM_VECTORS-1:0] diff;
    logic                   mismatch_q, mismatch_d;
    logic [IDX_W-1:0]       fail_idx_q, fail_idx_d;

    // Compare against the table being completed this edge so the result
    // lands together with the DONE state.
    assign diff = tt_d ^ exp_q;

    always_comb begin
        mismatch_d = mismatch_q;
        fail_idx_d = fail_idx_q;
        if (accept) begin
            mismatch_d = 1'b0;
            fail_idx_d = '0;
        end else if (last_sample) begin
            mismatch_d = |diff;
            fail_idx_d = '0;
            // Descending scan leaves the lowest differing index.
            for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
                if (diff[i]) fail_idx_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            exp_q <= expected_tt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    assign mismatch = mismatch_q;
    assign fail_idx = fail_idx_q;
`endif

endmodule

// File: tb/tb_combo_sweep_ctrl.sv
// Testbench for combo_sweep_ctrl (SETTLE_CYCLES = 2). A combinational model
// (XOR or AND of a,b,c) feeds y. Each accepted sweep pushes its expected
// result and done cycle into a queue; a monitor pops and compares on done.
module tb_combo_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       y;
    logic       a, b, c;
    logic       busy, done;
    logic [7:0] truth_table;
    logic [7:0] exp_in = 8'h00;
    int         mode = 0;
`ifdef COMBO_SWEEP_CHECK_EN
    logic       mismatch;
    logic [2:0] fail_idx;
`endif

    assign y = (mode == 1) ? (a & b & c) : (a ^ b ^ c);

    combo_sweep_ctrl #(
        .SETTLE_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .y          (y),
        .a          (a),
        .b          (b),
        .c          (c),
        .busy       (busy),
        .done       (done),
        .truth_table(truth_table)
`ifdef COMBO_SWEEP_CHECK_EN
        ,
        .expected_tt(exp_in),
        .mismatch   (mismatch),
        .fail_idx   (fail_idx)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] tt;
        int         dcyc;
        logic       mm;
        logic [2:0] fi;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding sweep.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("done_cycle", cyc, mon_e.dcyc);
                    chk("truth_table", truth_table, mon_e.tt);
`ifdef COMBO_SWEEP_CHECK_EN
                    chk("mismatch", mismatch, mon_e.mm);
                    chk("fail_idx", fail_idx, mon_e.fi);
`endif
                end
            end
        end
    end

    // Issue a sweep from the current negedge (IDLE assumed, or start already
    // held high). Checks busy and the vector sequence each cycle; returns at
    // the negedge of the cycle after DONE. With hold, start is left high.
    task automatic sweep(input int md, input logic [7:0] tt, input bit hold,
                         input logic [7:0] et, input logic mm, input logic [2:0] fi);
        exp_t e;
        mode   = md;
        exp_in = et;
        start  = 1'b1;
        e.tt   = tt;
        e.dcyc = cyc + 25;
        e.mm   = mm;
        e.fi   = fi;
        sbq.push_back(e);
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            if (j == 1 && !hold) start = 1'b0;
            if (j == 1) chk("tt_cleared", truth_table, 0);
            chk("busy_sweep", busy, 1);
            chk("abc_vector", {a, b, c}, (j - 1) / 3);
        end
        @(negedge clk);
        chk("busy_done_cycle", busy, 0);
        chk("abc_done_cycle", {a, b, c}, 7);
        @(negedge clk);
        chk("abc_after_done", {a, b, c}, 0);
        chk("busy_after_done", busy, 0);
        chk("done_after_done", done, 0);
        chk("tt_held", truth_table, tt);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_abc", {a, b, c}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tt", truth_table, 0);
`ifdef COMBO_SWEEP_CHECK_EN
        chk("rst_mismatch", mismatch, 0);
        chk("rst_fail_idx", fail_idx, 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // XOR model, single start pulse
        sweep(0, 8'h96, 1'b0, 8'h96, 1'b0, 3'd0);
        repeat (3) @(negedge clk);

        // AND model twice: second start clears and rebuilds the table
        sweep(1, 8'h80, 1'b0, 8'h80, 1'b0, 3'd0);
        repeat (2) @(negedge clk);
        sweep(1, 8'h80, 1'b0, 8'h80, 1'b0, 3'd0);
        repeat (2) @(negedge clk);

        // start held high: one sweep, next accepted one cycle after DONE
        sweep(0, 8'h96, 1'b1, 8'h96, 1'b0, 3'd0);
        sweep(0, 8'h96, 1'b0, 8'h96, 1'b0, 3'd0);
        repeat (2) @(negedge clk);

        // Reset mid-sweep: sampled at the edge ending cycle k+10
        mode  = 0;
        start = 1'b1;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            if (j == 10) rst_n = 1'b0;
            if (j == 11) rst_n = 1'b1;
        end
        chk("abort_abc", {a, b, c}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_tt", truth_table, 0);
        repeat (30) begin
            @(negedge clk);
            chk("abort_stays_idle", busy, 0);
        end
        sweep(0, 8'h96, 1'b0, 8'h96, 1'b0, 3'd0);
        repeat (2) @(negedge clk);

`ifdef COMBO_SWEEP_CHECK_EN
        sweep(0, 8'h96, 1'b0, 8'h96, 1'b0, 3'd0);
        repeat (2) @(negedge clk);
        sweep(0, 8'h96, 1'b0, 8'h97, 1'b1, 3'd0);
        repeat (2) @(negedge clk);
        sweep(0, 8'h96, 1'b0, 8'h16, 1'b1, 3'd7);
        repeat (2) @(negedge clk);
`endif

        begin
            int waited;
            waited = 0;
            while (sbq.size() != 0 && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            chk("scoreboard_drained", sbq.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
